// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator-computer sequencer: FSM states, ISA and
// ALU opcodes, SKIPCOND condition codes, datapath mux selects.
package acc_cpu_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F_MAR,
        ST_F_RD,
        ST_F_IR,
        ST_DECODE,
        ST_E_MAR,
        ST_E_RD,
        ST_E_MBR,
        ST_E_ACC,
        ST_E_WR,
        ST_HALTED
    } state_e;

    typedef enum logic [2:0] {
        CLS_MEM_READ,
        CLS_STORE,
        CLS_JUMP,
        CLS_SKIP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_MUL   = 4'h5;
    localparam logic [3:0] OP_DIV   = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'h7;
    localparam logic [3:0] OP_SKIP  = 4'h8;
    localparam logic [3:0] OP_JUMP  = 4'h9;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_MUL = 4'b0010;
    localparam logic [3:0] ALU_DIV = 4'b0011;

    localparam logic [1:0] COND_LT    = 2'b00;
    localparam logic [1:0] COND_EQ    = 2'b01;
    localparam logic [1:0] COND_GT    = 2'b10;
    localparam logic [1:0] COND_NEVER = 2'b11;

    localparam logic PC_SEL_INC  = 1'b0;
    localparam logic PC_SEL_IR   = 1'b1;
    localparam logic MAR_SEL_PC  = 1'b0;
    localparam logic MAR_SEL_IR  = 1'b1;
    localparam logic MBR_SEL_MEM = 1'b0;
    localparam logic MBR_SEL_ACC = 1'b1;
    localparam logic ACC_SEL_MBR = 1'b0;
    localparam logic ACC_SEL_ALU = 1'b1;

    // ACC is two's complement, so the sign bit alone decides "negative".
    function automatic logic skip_taken(input logic [1:0] cond, input logic [15:0] acc);
        logic taken;
        taken = 1'b0;
        case (cond)
            COND_LT: taken = acc[15];
            COND_EQ: taken = (acc == 16'h0000);
            COND_GT: taken = !acc[15] && (acc != 16'h0000);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/acc_decode.sv
// Opcode classifier: ir[15:12] -> instruction class plus ALU operation.
// MUL/DIV are only legal when ACC_SEQ_MULDIV_EN is defined.
module acc_decode
    import acc_cpu_pkg::*;
(
    input  logic [3:0]   opcode,
    output instr_class_e cls,
    output logic         use_alu,
    output logic [3:0]   alu_op
);

    always_comb begin
        cls     = CLS_ILLEGAL;
        use_alu = 1'b0;
        alu_op  = ALU_ADD;
        case (opcode)
            OP_LOAD:  cls = CLS_MEM_READ;
            OP_ADD: begin
                cls     = CLS_MEM_READ;
                use_alu = 1'b1;
                alu_op  = ALU_ADD;
            end
            OP_SUB: begin
                cls     = CLS_MEM_READ;
                use_alu = 1'b1;
                alu_op  = ALU_SUB;
            end
`ifdef ACC_SEQ_MULDIV_EN
            OP_MUL: begin
                cls     = CLS_MEM_READ;
                use_alu = 1'b1;
                alu_op  = ALU_MUL;
            end
            OP_DIV: begin
                cls     = CLS_MEM_READ;
                use_alu = 1'b1;
                alu_op  = ALU_DIV;
            end
`endif
            OP_STORE: cls = CLS_STORE;
            OP_JUMP:  cls = CLS_JUMP;
            OP_SKIP:  cls = CLS_SKIP;
            OP_HALT:  cls = CLS_HALT;
            default:  cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/acc_sequencer.sv
// Fetch/decode/execute control sequencer for the 16-bit accumulator computer.
// Optional MUL/DIV support is enabled by defining ACC_SEQ_MULDIV_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for run
// ST_F_MAR   | MAR <= PC
// ST_F_RD    | memory read latency for instruction fetch
// ST_F_IR    | IR <= memory, PC <= PC+1
// ST_DECODE  | classify IR; JUMP/SKIPCOND complete here, HALT/illegal stop
// ST_E_MAR   | MAR <= IR address (STORE also MBR <= ACC)
// ST_E_RD    | memory read latency for operand
// ST_E_MBR   | MBR <= memory
// ST_E_ACC   | ACC <= MBR or ALU result
// ST_E_WR    | memory[MAR] <= MBR
// ST_HALTED  | absorbing until reset
module acc_sequencer
    import acc_cpu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic [15:0] acc,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mar_we,
    output logic        mbr_we,
    output logic        acc_we,
    output logic        pc_sel,
    output logic        mar_sel,
    output logic        mbr_sel,
    output logic        acc_sel,
    output logic [3:0]  alu_op,
    output logic        mem_we,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
);

    state_e       state_q, state_d;
    logic         halted_q, halted_d;
    logic         illegal_q, illegal_d;
    instr_class_e dec_cls;
    logic         dec_use_alu;
    logic [3:0]   dec_alu_op;
    logic         unused_ir;

    assign unused_ir = ^ir[ADDR_W-3:0];

    acc_decode u_decode (
        .opcode  (ir[15:12]),
        .cls     (dec_cls),
        .use_alu (dec_use_alu),
        .alu_op  (dec_alu_op)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        mar_we     = 1'b0;
        mbr_we     = 1'b0;
        acc_we     = 1'b0;
        pc_sel     = PC_SEL_INC;
        mar_sel    = MAR_SEL_PC;
        mbr_sel    = MBR_SEL_MEM;
        acc_sel    = ACC_SEL_MBR;
        alu_op     = ALU_ADD;
        mem_we     = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            ST_IDLE: if (run) state_d = ST_F_MAR;
            ST_F_MAR: begin
                mar_we  = 1'b1;
                mar_sel = MAR_SEL_PC;
                state_d = ST_F_RD;
            end
            ST_F_RD: state_d = ST_F_IR;
            ST_F_IR: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = PC_SEL_INC;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (dec_cls)
                    CLS_MEM_READ, CLS_STORE: state_d = ST_E_MAR;
                    CLS_JUMP: begin
                        pc_we      = 1'b1;
                        pc_sel     = PC_SEL_IR;
                        instr_done = 1'b1;
                    end
                    CLS_SKIP: begin
                        // PC already points past this instruction, so one more
                        // increment skips the next one.
                        pc_we      = skip_taken(ir[ADDR_W-1 -: 2], acc);
                        pc_sel     = PC_SEL_INC;
                        instr_done = 1'b1;
                    end
                    CLS_HALT: begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end
                    default: begin
                        state_d   = ST_HALTED;
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_E_MAR: begin
                mar_we  = 1'b1;
                mar_sel = MAR_SEL_IR;
                if (dec_cls == CLS_STORE) begin
                    mbr_we  = 1'b1;
                    mbr_sel = MBR_SEL_ACC;
                    state_d = ST_E_WR;
                end else begin
                    state_d = ST_E_RD;
                end
            end
            ST_E_RD: state_d = ST_E_MBR;
            ST_E_MBR: begin
                mbr_we  = 1'b1;
                mbr_sel = MBR_SEL_MEM;
                state_d = ST_E_ACC;
            end
            ST_E_ACC: begin
                acc_we     = 1'b1;
                acc_sel    = dec_use_alu ? ACC_SEL_ALU : ACC_SEL_MBR;
                alu_op     = dec_use_alu ? dec_alu_op : ALU_ADD;
                instr_done = 1'b1;
            end
            ST_E_WR: begin
                mem_we     = 1'b1;
                instr_done = 1'b1;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase

        if (instr_done) state_d = run ? ST_F_MAR : ST_IDLE;

        // Outputs must be quiet while reset is held, whatever state the flops hold.
        if (reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            mar_we     = 1'b0;
            mbr_we     = 1'b0;
            acc_we     = 1'b0;
            pc_sel     = PC_SEL_INC;
            mar_sel    = MAR_SEL_PC;
            mbr_sel    = MBR_SEL_MEM;
            acc_sel    = ACC_SEL_MBR;
            alu_op     = ALU_ADD;
            mem_we     = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign halted  = halted_q & ~reset;
    assign illegal = illegal_q & ~reset;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: a small datapath around the sequencer plus an
// instruction-level model of the accumulator ISA that predicts PC/ACC/memory and cycle counts.
module tb_acc_sequencer;

`ifdef ACC_SEQ_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, run;
    logic [15:0] ir, acc;
    logic        pc_we, ir_we, mar_we, mbr_we, acc_we;
    logic        pc_sel, mar_sel, mbr_sel, acc_sel;
    logic [3:0]  alu_op;
    logic        mem_we, instr_done, halted, illegal;

    int tests = 0;
    int fails = 0;

    acc_sequencer #(.ADDR_W(12)) dut (
        .clock(clock), .reset(reset), .run(run), .ir(ir), .acc(acc),
        .pc_we(pc_we), .ir_we(ir_we), .mar_we(mar_we), .mbr_we(mbr_we), .acc_we(acc_we),
        .pc_sel(pc_sel), .mar_sel(mar_sel), .mbr_sel(mbr_sel), .acc_sel(acc_sel),
        .alu_op(alu_op), .mem_we(mem_we), .instr_done(instr_done),
        .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // datapath environment
    logic [15:0] mem [0:4095];
    logic [15:0] pc, mbr, alu_y;
    logic [11:0] mar;
    logic        ld_we = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [15:0] ld_data = '0;

    always_comb begin
        case (alu_op)
            4'b0000: alu_y = acc + mbr;
            4'b0001: alu_y = acc - mbr;
            4'b0010: alu_y = 16'(acc * mbr);
            4'b0011: alu_y = (mbr == 16'h0) ? 16'hFFFF : acc / mbr;
            default: alu_y = 16'h0;
        endcase
    end

    always @(posedge clock) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mar] <= mbr;
        if (reset) begin
            pc <= '0; mar <= '0; mbr <= '0; ir <= '0; acc <= '0;
        end else begin
            if (pc_we)  pc  <= pc_sel ? {4'h0, ir[11:0]} : pc + 16'd1;
            if (mar_we) mar <= mar_sel ? ir[11:0] : pc[11:0];
            if (ir_we)  ir  <= mem[mar];
            if (mbr_we) mbr <= mbr_sel ? acc : mem[mar];
            if (acc_we) acc <= acc_sel ? alu_y : mbr;
        end
    end

    // instruction-level reference model
    logic [15:0] ref_mem [0:4095];
    logic [15:0] m_pc, m_acc;
    bit          m_halted, m_illegal;

    task automatic model_step(output int len, output bit is_store, output logic [11:0] sa,
                              output logic [15:0] fetch_pc);
        logic [15:0] instr, opnd;
        logic [11:0] a;
        bit taken;
        fetch_pc = m_pc;
        instr    = ref_mem[m_pc[11:0]];
        a        = instr[11:0];
        opnd     = ref_mem[a];
        sa       = a;
        is_store = 1'b0;
        len      = 8;
        m_pc     = m_pc + 16'd1;
        case (instr[15:12])
            4'h1: m_acc = opnd;
            4'h2: begin ref_mem[a] = m_acc; is_store = 1'b1; len = 6; end
            4'h3: m_acc = m_acc + opnd;
            4'h4: m_acc = m_acc - opnd;
            4'h5: if (MULDIV) m_acc = 16'(m_acc * opnd);
                  else begin m_halted = 1; m_illegal = 1; len = 5; end
            4'h6: if (MULDIV) m_acc = (opnd == 16'h0) ? 16'hFFFF : m_acc / opnd;
                  else begin m_halted = 1; m_illegal = 1; len = 5; end
            4'h7: begin m_halted = 1; len = 5; end
            4'h8: begin
                len = 4;
                case (instr[11:10])
                    2'b00:   taken = $signed(m_acc) < 0;
                    2'b01:   taken = (m_acc == 16'h0);
                    2'b10:   taken = $signed(m_acc) > 0;
                    default: taken = 1'b0;
                endcase
                if (taken) m_pc = m_pc + 16'd1;
            end
            4'h9: begin m_pc = {4'h0, a}; len = 4; end
            default: begin m_halted = 1; m_illegal = 1; len = 5; end
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {pc_we, ir_we, mar_we, mbr_we, acc_we, mem_we, instr_done};
    endfunction

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        ld_addr = a; ld_data = d; ld_we = 1'b1;
        ref_mem[a] = d;
        @(negedge clock);
        ld_we = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b1; run = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_strobes", 32'(strobes()), 0);
        check("rst_selects", {24'h0, pc_sel, mar_sel, mbr_sel, acc_sel, alu_op}, 0);
        check("rst_flags", {30'h0, halted, illegal}, 0);
        m_pc = '0; m_acc = '0; m_halted = 0; m_illegal = 0;
    endtask

    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check(tag, 32'(strobes()), 0);
        end
    endtask

    task automatic exec_instr(input bit drop_run);
        int len, count, we_cnt, we_cyc;
        bit is_store, seen;
        logic [11:0] sa;
        logic [15:0] fpc;
        model_step(len, is_store, sa, fpc);
        count = 0; we_cnt = 0; we_cyc = 0; seen = 0;
        while (count < 30 && !seen) begin
            @(negedge clock);
            count++;
            if (drop_run && count == 3) run = 1'b0;
            if (mem_we) begin we_cnt++; we_cyc = count; end
            if (count == 2) check("fetch_mar", 32'(mar), 32'(fpc[11:0]));
            if (instr_done || halted) seen = 1;
        end
        check("instr_len", count, len);
        check("mem_we_cnt", we_cnt, is_store ? 1 : 0);
        if (is_store) check("mem_we_cycle", we_cyc, 6);
        @(posedge clock);
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("acc", 32'(acc), 32'(m_acc));
        check("flags", {30'h0, halted, illegal}, {30'h0, m_halted, m_illegal});
        if (is_store) check("store_mem", 32'(mem[sa]), 32'(ref_mem[sa]));
        if (m_halted) begin
            quiet("halt_quiet", 3);
        end else if (!run) begin
            quiet("idle_quiet", 2);
            run = 1'b1;
        end
    endtask

    task automatic run_until_halt(input int limit, input bit random_drop);
        int n;
        n = 0;
        while (!m_halted && n < limit) begin
            exec_instr(random_drop && ($urandom_range(0, 3) == 0));
            n++;
        end
    endtask

    function automatic logic [15:0] rand_instr();
        int r;
        logic [11:0] da;
        r  = $urandom_range(0, 99);
        da = 12'h100 + 12'($urandom_range(0, 15));
        if (r < 16)      return {4'h1, da};
        else if (r < 32) return {4'h3, da};
        else if (r < 44) return {4'h4, da};
        else if (r < 47) return {4'h5, da};
        else if (r < 50) return {4'h6, da};
        else if (r < 64) return {4'h2, da};
        else if (r < 74) return {4'h9, 12'($urandom_range(0, 255))};
        else if (r < 92) return {4'h8, 2'($urandom_range(0, 3)), 10'h0};
        else if (r < 96) return 16'h7000;
        else             return {4'hA + 4'($urandom_range(0, 5)), 12'h0};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; run = 1'b1;
        @(negedge clock);
        check("rst_strobes_run", 32'(strobes()), 0);
        check("rst_flags0", {30'h0, halted, illegal}, 0);
        for (int i = 0; i < 4096; i++) poke(12'(i), 16'h0);
        restart();

        // directed program
        poke(12'h000, 16'h1010); poke(12'h001, 16'h3011); poke(12'h002, 16'h2012);
        poke(12'h003, 16'h4012); poke(12'h004, 16'h8400); poke(12'h005, 16'h7000);
        poke(12'h006, 16'h9020); poke(12'h020, 16'h4013); poke(12'h021, 16'h8400);
        poke(12'h022, 16'h8000); poke(12'h023, 16'h7000); poke(12'h024, 16'h7000);
        poke(12'h010, 16'h0005); poke(12'h011, 16'h0003); poke(12'h013, 16'h0001);
        reset = 1'b0; run = 1'b1;
        exec_instr(0);
        check("load_acc", 32'(acc), 32'h0005);
        check("load_pc", 32'(pc), 32'h0001);
        exec_instr(0);
        exec_instr(0);
        check("store_mem12", 32'(mem[12'h012]), 32'h0008);
        run_until_halt(20, 0);
        check("dir_halt_pc", 32'(pc), 32'h0025);

        // illegal opcodes
        restart();
        poke(12'h000, 16'hA000);
        reset = 1'b0; run = 1'b1;
        exec_instr(0);
        check("illegal_A", {30'h0, halted, illegal}, 32'h3);
        restart();
        poke(12'h000, 16'h5010);
        reset = 1'b0; run = 1'b1;
        run_until_halt(3, 0);

        // reset during E_WR suppresses the write
        restart();
        poke(12'h000, 16'h2012);
        reset = 1'b0; run = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_ewr_mem_we", 32'(mem_we), 0);
        check("rst_ewr_strobes", 32'(strobes()), 0);
        @(negedge clock);
        check("rst_ewr_mem", 32'(mem[12'h012]), 32'(ref_mem[12'h012]));
        reset = 1'b0; run = 1'b0;
        quiet("rst_ewr_idle", 3);
        check("rst_ewr_flags", {30'h0, halted, illegal}, 0);
        m_pc = '0; m_acc = '0; m_halted = 0; m_illegal = 0;
        run = 1'b1;
        exec_instr(0);

        // randomized programs
        for (int round = 0; round < 8; round++) begin
            restart();
            for (int a = 0; a < 256; a++) poke(12'(a), rand_instr());
            for (int a = 0; a < 16; a++) poke(12'h100 + 12'(a), 16'($urandom()));
            reset = 1'b0; run = 1'b1;
            run_until_halt(40, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
